uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between N_REQ byte producers, e.g. a debug console, MIC-1 output port and status reporter.
- Grants round-robin, with packet locking so multi-byte messages are never interleaved.
- Latches each granted byte and holds it stable on the transmitter data input for the whole frame.
- Sequences tx_start against the transmitter's tx_busy/tx_done handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of grant id.
- ACK_TIMEOUT, 1024, clk cycles allowed between tx_start and observing uart_busy=1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester byte available
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  byte is the last of a packet, which ends the lock
- req_ready  out  N_REQ  one-hot, 1-cycle pulse; the byte is accepted in that cycle
- uart_tx_start  out  1  start pulse to the transmitter
- uart_data  out  8  byte to the transmitter, held stable for the whole frame
- uart_busy  in  1  transmitter busy
- uart_done  in  1  transmitter stop-bit indication
- grant_id  out  ID_W  requester currently owning the line
- locked  out  1  a packet is in progress
- ack_err  out  1  1-cycle pulse on ACK timeout

Behaviour:
- Reset values, applied on any clk edge with rst=1, including mid-frame:
  - state=ARB, rr_ptr=0, locked=0, grant_id=0, uart_data=8'h00.
  - req_ready=0, uart_tx_start=0, ack_err=0, timeout counter=0.
- ARB:
  - When unlocked, select the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - When locked, consider only grant_id and wait indefinitely for its req_valid.
  - On selecting requester k:
    - pulse req_ready[k] and latch req_data[k] into uart_data.
    - set grant_id=k.
    - if req_last[k]=0, set locked=1 and store last_flag=0.
    - if req_last[k]=1, store last_flag=1.
    - go to START.
  - No selection → stay in ARB.
- START:
  - uart_tx_start=1 for exactly this one cycle; clear the timeout counter.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - uart_busy=1 → go to WAIT_DONE.
  - Otherwise increment the counter. When counter reaches ACK_TIMEOUT-1, pulse ack_err, set locked=0 and rr_ptr=grant_id+1, then go to ARB.
  - On timeout the byte is dropped, not retried.
- WAIT_DONE:
  - uart_done=1 → go to RELEASE.
- RELEASE:
  - Wait for uart_busy=0. That cycle:
    - if last_flag=1, set locked=0 and rr_ptr=(grant_id+1) mod N_REQ.
    - go to ARB.
- Gaps and latency:
  - Minimum gap between consecutive tx_start pulses is frame length + 3 cycles (RELEASE→ARB→START).
  - Latency from req_valid (line idle) to uart_tx_start is 2 cycles.
- uart_data changes only on the ARB accept cycle, so it is constant from START through RELEASE.
- req_ready is never asserted outside ARB and never for more than one requester.
- A requester dropping req_valid while locked keeps the lock, so the line stalls; this is by design.
- Simultaneous req_valid on all inputs → strict rotation, one packet each.
- uart_done and uart_busy falling in the same cycle is handled: WAIT_DONE→RELEASE, then RELEASE exits next cycle.

Decomposition:
- Shared package uart_pkg:
  - enum arb_state_t {ARB, START, WAIT_ACK, WAIT_DONE, RELEASE}.
  - localparam DATA_BITS=8.
- Sub-module rr_select (N_REQ, ID_W): combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: found, index.
  - Reused later by other arbiters.

Test Plan:
1. Single byte: req_valid[2]=1, req_data=8'hA5, req_last=1 → req_ready[2] pulse, uart_tx_start 2 cycles later, uart_data=A5 stable through frame, rr_ptr=3 after release.
2. Round-robin: all four valid with single-byte packets 8'h10,8'h20,8'h30,8'h40 → transmit order 10,20,30,40; then requester 0 again; grant_id sequence 0,1,2,3,0.
3. Packet lock: requester 1 sends 3 bytes 8'h01,8'h02,8'h03 (last on third) while requester 0 is valid throughout → no req_ready[0] until 03's RELEASE; locked=1 for bytes 1–2.
4. Timeout: uart_busy tied 0 with ACK_TIMEOUT=16 → ack_err pulse 16 cycles after START, locked=0, arbiter returns to ARB and serves the next requester.
5. Reset mid-frame: assert rst during WAIT_DONE → next cycle all outputs at reset values, state ARB; the following request is served normally.
6. Stalled lock: requester 3 sends a non-last byte then drops req_valid for 50 cycles while requester 0 is valid → no grant to 0 until requester 3 sends a req_last byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter and related blocks.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ARB,
        START,
        WAIT_ACK,
        WAIT_DONE,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  index
);

    // Walk ptr, ptr+1, ... modulo N_REQ and keep the first hit
    always_comb begin
        logic [ID_W-1:0] cand;
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers. Round-robin
// grant with packet locking; the granted byte is held on uart_data for the
// whole frame, and tx_start is sequenced against the busy/done handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [DATA_BITS*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       uart_tx_start,
    output logic [DATA_BITS-1:0]       uart_data,
    input  logic                       uart_busy,
    input  logic                       uart_done,
    output logic [ID_W-1:0]            grant_id,
    output logic                       locked,
    output logic                       ack_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_idx;
    logic            rr_found;
    logic [ID_W-1:0] sel_idx;
    logic            sel_found;
    logic [ID_W-1:0] next_ptr;
    logic            last_flag;
    logic [CNT_W-1:0] ack_cnt;

    rr_select #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (rr_found),
        .index (rr_idx)
    );

    // While a packet is open only its owner may be chosen, and we wait on it forever
    always_comb begin
        sel_idx   = locked ? grant_id : rr_idx;
        sel_found = locked ? req_valid[grant_id] : rr_found;
    end

    // Rotation restarts just past the requester that last owned the line
    assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Accept handshake: one-hot, only in ARB, and the byte is latched at this edge
    always_comb begin
        req_ready = '0;
        if (!rst && state == ARB && sel_found)
            req_ready[sel_idx] = 1'b1;
    end

    // Main sequencer; start and error are one-cycle registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB;
            rr_ptr        <= '0;
            locked        <= 1'b0;
            grant_id      <= '0;
            uart_data     <= '0;
            uart_tx_start <= 1'b0;
            ack_err       <= 1'b0;
            ack_cnt       <= '0;
            last_flag     <= 1'b0;
        end else begin
            uart_tx_start <= 1'b0;
            ack_err       <= 1'b0;
            case (state)
                ARB: begin
                    if (sel_found) begin
                        uart_data <= req_data[int'(sel_idx)*DATA_BITS +: DATA_BITS];
                        grant_id  <= sel_idx;
                        last_flag <= req_last[sel_idx];
                        if (!req_last[sel_idx])
                            locked <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    uart_tx_start <= 1'b1;
                    ack_cnt       <= '0;
                    state         <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        // Transmitter never answered: drop the byte and reopen arbitration
                        ack_err <= 1'b1;
                        locked  <= 1'b0;
                        rr_ptr  <= next_ptr;
                        state   <= ARB;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (uart_done)
                        state <= RELEASE;
                end
                RELEASE: begin
                    if (!uart_busy) begin
                        if (last_flag) begin
                            locked <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model and
// per-requester byte queues.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           uart_tx_start;
    logic [7:0]     uart_data;
    logic           uart_busy = 1'b0;
    logic           uart_done = 1'b0;
    logic [1:0]     grant_id;
    logic           locked;
    logic           ack_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .ID_W        (2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_start (uart_tx_start),
        .uart_data     (uart_data),
        .uart_busy     (uart_busy),
        .uart_done     (uart_done),
        .grant_id      (grant_id),
        .locked        (locked),
        .ack_err       (ack_err)
    );

    int nvec = 0;
    int nerr = 0;

    // producer queues: {last, data}
    logic [8:0] pq [N][16];
    int         head [N];
    int         tail [N];
    logic [N-1:0] hold = '0;
    logic [N-1:0] acc  = '0;

    // transmitter model and logs
    int         tcnt = 0;
    logic       tx_en = 1'b1;
    logic [7:0] cur = 8'h00;
    logic [7:0] tx_byte [64];
    logic [1:0] tx_gid  [64];
    logic       tx_lck  [64];
    int         n_tx = 0;
    int         rdy_log [64];
    int         n_rdy = 0;
    int         stable_err = 0;
    int         onehot_err = 0;
    int         cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_tx(input string tag, input int idx, input logic [7:0] b, input logic [1:0] g);
        chk(tag, {22'd0, tx_gid[idx], tx_byte[idx]}, {22'd0, g, b});
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        pq[r][tail[r]] = {last, d};
        tail[r]++;
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += tail[i] - head[i];
        return p;
    endfunction

    // one clock: transmitter model, producers, then sample outputs
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst) begin
            tcnt      = 0;
            uart_busy = 1'b0;
            uart_done = 1'b0;
        end else begin
            if (tcnt > 0) begin
                if (uart_data !== cur) stable_err++;
                tcnt--;
                uart_done = (tcnt == 1);
                uart_busy = (tcnt != 0);
            end
            if (uart_tx_start) begin
                tx_byte[n_tx] = uart_data;
                tx_gid[n_tx]  = grant_id;
                tx_lck[n_tx]  = locked;
                n_tx++;
                if (tx_en) begin
                    tcnt      = FRAME;
                    uart_busy = 1'b1;
                    uart_done = 1'b0;
                    cur       = uart_data;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) head[i]++;
            if (head[i] < tail[i] && !hold[i]) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = pq[i][head[i]][8];
                req_data[8*i +: 8] = pq[i][head[i]][7:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
        #1;
        acc = req_ready;
        if ($countones(acc) > 1) onehot_err++;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                rdy_log[n_rdy] = i;
                n_rdy++;
            end
    endtask

    task automatic drain();
        int quiet = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (pending() == 0 && tcnt == 0 && !uart_tx_start) quiet++;
            else quiet = 0;
            if (quiet >= 20) return;
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int base, rb, ts, te, r0;
        logic lck_ts, lck_te, ok;

        // reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_grant", grant_id, 0);
        chk("rst_locked", locked, 0);
        chk("rst_data", uart_data, 0);
        chk("rst_start", uart_tx_start, 0);
        chk("rst_ackerr", ack_err, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;
        step();

        // single byte with exact latency
        base = n_tx;
        push(2, 1'b1, 8'hA5);
        step();
        chk("t1_ready", acc, 4'b0100);
        chk("t1_start_accept_cyc", uart_tx_start, 0);
        step();
        chk("t1_start_next_cyc", uart_tx_start, 0);
        step();
        chk("t1_start_2_cyc", uart_tx_start, 1);
        chk("t1_data", uart_data, 8'hA5);
        chk("t1_gid", grant_id, 2);
        drain();
        chk_tx("t1_tx", base, 8'hA5, 2'd2);
        chk("t1_unlocked", locked, 0);

        // pointer now 3: requester 3 beats requester 0
        base = n_tx;
        push(0, 1'b1, 8'h55);
        push(3, 1'b1, 8'h66);
        drain();
        chk_tx("t1_ptr_first", base, 8'h66, 2'd3);
        chk_tx("t1_ptr_second", base + 1, 8'h55, 2'd0);

        // round robin from pointer 0
        do_reset();
        base = n_tx;
        push(0, 1'b1, 8'h10);
        push(1, 1'b1, 8'h20);
        push(2, 1'b1, 8'h30);
        push(3, 1'b1, 8'h40);
        push(0, 1'b1, 8'h11);
        drain();
        chk_tx("t2_rr0", base,     8'h10, 2'd0);
        chk_tx("t2_rr1", base + 1, 8'h20, 2'd1);
        chk_tx("t2_rr2", base + 2, 8'h30, 2'd2);
        chk_tx("t2_rr3", base + 3, 8'h40, 2'd3);
        chk_tx("t2_rr4", base + 4, 8'h11, 2'd0);

        // packet lock: pointer is 1, requester 0 waiting throughout
        base = n_tx;
        rb   = n_rdy;
        push(1, 1'b0, 8'h01);
        push(1, 1'b0, 8'h02);
        push(1, 1'b1, 8'h03);
        push(0, 1'b1, 8'h77);
        drain();
        chk_tx("t3_b1", base,     8'h01, 2'd1);
        chk_tx("t3_b2", base + 1, 8'h02, 2'd1);
        chk_tx("t3_b3", base + 2, 8'h03, 2'd1);
        chk_tx("t3_b4", base + 3, 8'h77, 2'd0);
        chk("t3_lock_b1", tx_lck[base], 1);
        chk("t3_lock_b2", tx_lck[base + 1], 1);
        chk("t3_lock_other", tx_lck[base + 3], 0);
        chk("t3_ready_order", {rdy_log[rb][3:0], rdy_log[rb+1][3:0], rdy_log[rb+2][3:0], rdy_log[rb+3][3:0]},
            16'h1110);

        // ack timeout: transmitter silent, pointer 1 selects requester 2
        tx_en = 1'b0;
        base  = n_tx;
        push(2, 1'b0, 8'hC3);
        push(3, 1'b1, 8'hD4);
        ts = -1;
        te = -1;
        lck_ts = 1'b0;
        lck_te = 1'b1;
        for (int k = 0; k < 60 && te < 0; k++) begin
            step();
            if (uart_tx_start && ts < 0) begin
                ts = cyc;
                lck_ts = locked;
            end
            if (ack_err && te < 0) begin
                te = cyc;
                lck_te = locked;
                tx_en = 1'b1;
            end
        end
        tx_en = 1'b1;
        chk("t4_ack_seen", te >= 0, 1);
        chk("t4_ack_latency", te - ts, 16);
        chk("t4_locked_before", lck_ts, 1);
        chk("t4_locked_after", lck_te, 0);
        drain();
        chk_tx("t4_dropped", base,     8'hC3, 2'd2);
        chk_tx("t4_next",    base + 1, 8'hD4, 2'd3);

        // reset in the middle of a frame
        push(1, 1'b0, 8'hE1);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (tcnt == 3) ok = 1'b1;
        end
        chk("t5_reach_frame", ok, 1);
        chk("t5_locked_before", locked, 1);
        rst = 1'b1;
        step();
        chk("t5_grant", grant_id, 0);
        chk("t5_locked", locked, 0);
        chk("t5_data", uart_data, 0);
        chk("t5_start", uart_tx_start, 0);
        chk("t5_ackerr", ack_err, 0);
        chk("t5_ready", req_ready, 0);
        rst = 1'b0;
        base = n_tx;
        push(2, 1'b1, 8'hB2);
        drain();
        chk_tx("t5_after", base, 8'hB2, 2'd2);

        // stalled lock: pointer 3, owner drops valid for 50 cycles
        base = n_tx;
        push(3, 1'b0, 8'h31);
        push(3, 1'b1, 8'h32);
        push(0, 1'b1, 8'h90);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            step();
            if (acc[3]) ok = 1'b1;
        end
        chk("t6_first_grant", ok, 1);
        hold[3] = 1'b1;
        r0 = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc[0]) r0++;
        end
        chk("t6_no_grant0", r0, 0);
        chk("t6_locked", locked, 1);
        hold[3] = 1'b0;
        drain();
        chk_tx("t6_b1", base,     8'h31, 2'd3);
        chk_tx("t6_b2", base + 1, 8'h32, 2'd3);
        chk_tx("t6_b3", base + 2, 8'h90, 2'd0);

        chk("data_stable", stable_err, 0);
        chk("ready_onehot", onehot_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
